// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Multi-cycle ALU operation sequencer. Accepts one request at a
//               time over a valid/ready handshake and latches the operands.
//               ADD/SUB/AND/OR/XOR finish in a single EXEC cycle. SHL/SHR/MUL
//               iterate one bit per cycle in ITER. The result is held in DONE
//               until the consumer accepts it.
// Ports       : clk, rst (sync, active-high)
//               req_valid/req_ready : request handshake (op, a, b)
//               res_valid/res_ready : result handshake (result, carry, zero)
//               busy                : sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 zero,
    output logic                 busy
);

    // Counter must be able to hold WIDTH itself (the MUL pass count).
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [CW-1:0]    c_cnt_width = CW'(WIDTH);
    localparam logic [WIDTH-1:0] c_b_width   = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] c_zero_w    = '0;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_work;   // shift register; multiplicand for MUL
    logic [2*WIDTH-1:0]   r_acc;    // MUL partial-product accumulator
    logic                 r_sh_c;   // last bit shifted out
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_carry;
    logic                 r_zero;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_c;
    logic [CW-1:0]        w_shift_cnt;

    assign req_ready = (r_state == S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign carry     = r_carry;
    assign zero      = r_zero;

    // Shift count is clamped to WIDTH: larger counts give the same result.
    assign w_shift_cnt = (b > c_b_width) ? c_cnt_width : CW'(b);

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    // The extra top bit of the widened difference is the borrow (a < b).
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (r_op)
            OP_ADD: begin w_alu_res = w_sum[WIDTH-1:0];  w_alu_c = w_sum[WIDTH];  end
            OP_SUB: begin w_alu_res = w_diff[WIDTH-1:0]; w_alu_c = w_diff[WIDTH]; end
            OP_AND: w_alu_res = r_a & r_b;
            OP_OR:  w_alu_res = r_a | r_b;
            OP_XOR: w_alu_res = r_a ^ r_b;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req_valid) begin
                if (op == OP_SHL || op == OP_SHR || op == OP_MUL) w_state_nxt = S_ITER;
                else                                              w_state_nxt = S_EXEC;
            end
            S_EXEC: w_state_nxt = S_DONE;
            S_ITER: if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_work   <= '0;
            r_acc    <= '0;
            r_sh_c   <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_op   <= op;
                    r_a    <= a;
                    r_b    <= b;
                    r_acc  <= '0;
                    r_sh_c <= 1'b0;
                    r_work <= {c_zero_w, a};
                    if (op == OP_MUL)                      r_cnt <= c_cnt_width;
                    else if (op == OP_SHL || op == OP_SHR) r_cnt <= w_shift_cnt;
                    else                                   r_cnt <= '0;
                end
                S_EXEC: begin
                    r_result <= {c_zero_w, w_alu_res};
                    r_carry  <= w_alu_c;
                    r_zero   <= (w_alu_res == c_zero_w);
                end
                S_ITER: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                        case (r_op)
                            OP_SHL: begin
                                r_sh_c <= r_work[WIDTH-1];
                                r_work <= {c_zero_w, r_work[WIDTH-2:0], 1'b0};
                            end
                            OP_SHR: begin
                                r_sh_c <= r_work[0];
                                r_work <= {c_zero_w, 1'b0, r_work[WIDTH-1:1]};
                            end
                            default: begin
                                // Shift-add: add the shifted multiplicand when
                                // the current multiplier LSB is set.
                                if (r_b[0]) r_acc <= r_acc + r_work;
                                r_work <= {r_work[2*WIDTH-2:0], 1'b0};
                                r_b    <= {1'b0, r_b[WIDTH-1:1]};
                            end
                        endcase
                    end else if (r_op == OP_MUL) begin
                        r_result <= r_acc;
                        r_carry  <= 1'b0;
                        r_zero   <= (r_acc == '0);
                    end else begin
                        r_result <= {c_zero_w, r_work[WIDTH-1:0]};
                        r_carry  <= r_sh_c;
                        r_zero   <= (r_work[WIDTH-1:0] == c_zero_w);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer (WIDTH=4). Directed
//               scenarios plus randomized operations compared against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic [2*W-1:0] result;
    logic         carry;
    logic         zero;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected result, carry and latency (edges from the
    // accept edge to the first edge at which res_valid is sampled high).
    function automatic void model(input logic [2:0] m_op, input logic [W-1:0] m_a,
                                  input logic [W-1:0] m_b, output logic [2*W-1:0] m_res,
                                  output logic m_c, output int m_lat);
        int ia, ib, n, t;
        ia = int'(m_a);
        ib = int'(m_b);
        n  = (ib > W) ? W : ib;
        m_c   = 1'b0;
        m_lat = 2;
        t     = 0;
        case (m_op)
            3'd0: begin t = ia + ib;            m_c = (t >= (1 << W)); t = t % (1 << W); end
            3'd1: begin t = (ia - ib + (1 << W)) % (1 << W); m_c = (ia < ib); end
            3'd2: t = ia & ib;
            3'd3: t = ia | ib;
            3'd4: t = ia ^ ib;
            3'd5: begin
                t = (ia << n) % (1 << W);
                if (n > 0) m_c = ((ia >> (W - n)) & 1) == 1;
                m_lat = 2 + n;
            end
            3'd6: begin
                t = ia >> n;
                if (n > 0) m_c = ((ia >> (n - 1)) & 1) == 1;
                m_lat = 2 + n;
            end
            default: begin t = ia * ib; m_lat = 2 + W; end
        endcase
        m_res = (2*W)'(t);
    endfunction

    // Issues one request with res_ready=1 and reports what came back. Inputs
    // are scrambled right after acceptance to show they are not re-sampled.
    task automatic run_op(input logic [2:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                          output int lat, output logic [2*W-1:0] res, output logic c,
                          output logic z, output logic busy_ok, output logic timeout);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; op = t_op; a = t_a; b = t_b; res_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0;
                op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            end
            if (!res_valid && busy !== 1'b1) busy_ok = 1'b0;
        end while (!res_valid && lat < 100);
        timeout = !res_valid || (guard >= 50);
        res = result;
        c   = carry;
        z   = zero;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b1; op = 3'd0; a = 4'h3; b = 4'h4; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h exp=00", result); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if ({carry, zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {carry, zero}); end
        rst = 1'b0; req_valid = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [2:0] t_op, input logic [W-1:0] t_a,
                            input logic [W-1:0] t_b);
        int lat, elat;
        logic [2*W-1:0] res, eres;
        logic c, z, bok, to, ec;
        model(t_op, t_a, t_b, eres, ec, elat);
        run_op(t_op, t_a, t_b, lat, res, c, z, bok, to);
        n_checks++;
        if (to || res !== eres || c !== ec || z !== (eres == '0) || lat != elat) begin
            n_fail++;
            $display("FAIL %s op=%0d a=%h b=%h got res=%h c=%b z=%b lat=%0d to=%b exp res=%h c=%b z=%b lat=%0d",
                     name, t_op, t_a, t_b, res, c, z, lat, to, eres, ec, (eres == '0), elat);
        end
    endtask

    task automatic test_add_sub;
        int lat;
        logic [2*W-1:0] res;
        logic c, z, bok, to;
        run_op(3'd0, 4'hF, 4'h1, lat, res, c, z, bok, to);
        n_checks++; if ({to, res, c, z} !== {1'b0, 8'h00, 1'b1, 1'b1} || lat != 2) begin
            n_fail++; $display("FAIL add_F_1 got res=%h c=%b z=%b lat=%0d exp res=00 c=1 z=1 lat=2", res, c, z, lat); end
        run_op(3'd1, 4'h3, 4'h5, lat, res, c, z, bok, to);
        n_checks++; if ({to, res, c, z} !== {1'b0, 8'h0E, 1'b1, 1'b0} || lat != 2) begin
            n_fail++; $display("FAIL sub_3_5 got res=%h c=%b z=%b lat=%0d exp res=0e c=1 z=0 lat=2", res, c, z, lat); end
    endtask

    task automatic test_mul;
        int lat;
        logic [2*W-1:0] res;
        logic c, z, bok, to;
        run_op(3'd7, 4'hF, 4'hF, lat, res, c, z, bok, to);
        n_checks++; if ({to, res, c, z} !== {1'b0, 8'hE1, 1'b0, 1'b0} || lat != 6) begin
            n_fail++; $display("FAIL mul_F_F got res=%h c=%b z=%b lat=%0d exp res=e1 c=0 z=0 lat=6", res, c, z, lat); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL mul_busy got=%b exp=1", bok); end
    endtask

    task automatic test_shifts;
        int lat;
        logic [2*W-1:0] res;
        logic c, z, bok, to;
        run_op(3'd5, 4'b1011, 4'd2, lat, res, c, z, bok, to);
        n_checks++; if ({to, res, c, z} !== {1'b0, 8'h0C, 1'b0, 1'b0} || lat != 4) begin
            n_fail++; $display("FAIL shl_2 got res=%h c=%b z=%b lat=%0d exp res=0c c=0 z=0 lat=4", res, c, z, lat); end
        run_op(3'd6, 4'b1011, 4'd5, lat, res, c, z, bok, to);
        n_checks++; if ({to, res, c, z} !== {1'b0, 8'h00, 1'b1, 1'b1} || lat != 6) begin
            n_fail++; $display("FAIL shr_clamp got res=%h c=%b z=%b lat=%0d exp res=00 c=1 z=1 lat=6", res, c, z, lat); end
        run_op(3'd5, 4'b1011, 4'd0, lat, res, c, z, bok, to);
        n_checks++; if ({to, res, c, z} !== {1'b0, 8'h0B, 1'b0, 1'b0} || lat != 2) begin
            n_fail++; $display("FAIL shl_0 got res=%h c=%b z=%b lat=%0d exp res=0b c=0 z=0 lat=2", res, c, z, lat); end
    endtask

    task automatic test_backpressure;
        int guard;
        @(negedge clk);
        req_valid = 1'b1; op = 3'd0; a = 4'h5; b = 4'h6; res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op = 3'd1; a = 4'h9; b = 4'h2;      // pending request, must wait
        guard = 0;
        while (!res_valid && guard < 20) begin @(negedge clk); guard++; end
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b exp=1", res_valid); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({result, carry, zero, req_ready, res_valid} !== {8'h0B, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got res=%h c=%b z=%b rr=%b rv=%b exp res=0b c=0 z=0 rr=0 rv=1",
                         i, result, carry, zero, req_ready, res_valid);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({req_ready, res_valid, busy} !== 3'b100) begin
            n_fail++; $display("FAIL bp_idle got rr/rv/busy=%b exp=100", {req_ready, res_valid, busy}); end
        @(negedge clk);
        n_checks++; if ({req_ready, busy} !== 2'b01) begin
            n_fail++; $display("FAIL bp_accept got rr/busy=%b exp=01", {req_ready, busy}); end
        req_valid = 1'b0;
        guard = 0;
        while (!res_valid && guard < 20) begin @(negedge clk); guard++; end
        n_checks++; if ({res_valid, result, carry, zero} !== {1'b1, 8'h07, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL bp_pending got rv=%b res=%h c=%b z=%b exp rv=1 res=07 c=0 z=0",
                               res_valid, result, carry, zero); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        logic seen;
        int lat;
        logic [2*W-1:0] res;
        logic c, z, bok, to;
        @(negedge clk);
        req_valid = 1'b1; op = 3'd7; a = 4'h7; b = 4'h3; res_ready = 1'b1;
        @(posedge clk);                 // accept
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;     // second ITER cycle
        @(negedge clk); rst = 1'b0;
        n_checks++; if ({req_ready, busy, res_valid, result} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL midrst_idle got rr=%b busy=%b rv=%b res=%h exp rr=1 busy=0 rv=0 res=00",
                               req_ready, busy, res_valid, result); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (res_valid) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_valid got=%b exp=0", seen); end
        run_op(3'd0, 4'h2, 4'h2, lat, res, c, z, bok, to);
        n_checks++; if ({to, res, c, z} !== {1'b0, 8'h04, 1'b0, 1'b0} || lat != 2) begin
            n_fail++; $display("FAIL midrst_add got res=%h c=%b z=%b lat=%0d exp res=04 c=0 z=0 lat=2", res, c, z, lat); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            check_op("random", 3'($urandom), W'($urandom), W'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; op = '0; a = '0; b = '0; res_ready = 1'b0;
        test_reset();
        test_add_sub();
        test_mul();
        test_shifts();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
